// File: rtl/axis_stream_loader.sv
// rtl/axis_stream_loader.sv - AXI-stream ingress: counted weight load, then buffered pixel stream with frame counting.
// Optional tlast protocol checking in the weight phase is enabled by defining LOADER_TLAST_CHECK_EN.
module axis_stream_loader #(
    parameter int DATA_W       = 32,
    parameter int PIX_W        = 24,
    parameter int WEIGHT_COUNT = 99678,
    parameter int FRAME_PIXELS = 65536,
    parameter int FIFO_DEPTH   = 16,
    localparam int WA  = (WEIGHT_COUNT > 1) ? $clog2(WEIGHT_COUNT) : 1,
    localparam int PCW = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1,
    localparam int AW  = $clog2(FIFO_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    input  logic              reload,
    output logic              w_valid,
    output logic [WA-1:0]     w_addr,
    output logic [DATA_W-1:0] w_data,
    output logic              weights_loaded,
    output logic              pix_valid,
    output logic [PIX_W-1:0]  pix_data,
    input  logic              pix_rd_en,
    output logic              frame_done,
    output logic [15:0]       frame_cnt,
    output logic              err_tlast
);

    typedef enum logic {LOAD_W = 1'b0, STREAM = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [WA-1:0]      w_cnt_q, w_cnt_d;
    logic [PCW-1:0]     pix_cnt_q, pix_cnt_d;
    logic               w_valid_q, w_valid_d;
    logic [WA-1:0]      w_addr_q, w_addr_d;
    logic [DATA_W-1:0]  w_data_q, w_data_d;
    logic               frame_done_q, frame_done_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic               err_q, err_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic [PIX_W-1:0]   mem_q [FIFO_DEPTH];

    logic fifo_full, fifo_empty, accept, push, pop, w_last;

    assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    // No pop credit in the same cycle: a full FIFO stalls the stream even while draining.
    assign s_axis_tready = !rst && !reload && ((state_q == LOAD_W) || !fifo_full);
    assign accept = s_axis_tvalid && s_axis_tready;
    assign push   = accept && (state_q == STREAM);
    assign pop    = pix_rd_en && !fifo_empty && !reload;
    assign w_last = (w_cnt_q == WA'(WEIGHT_COUNT - 1));

    always_comb begin
        state_d      = state_q;
        w_cnt_d      = w_cnt_q;
        pix_cnt_d    = pix_cnt_q;
        w_valid_d    = 1'b0;
        w_addr_d     = w_addr_q;
        w_data_d     = w_data_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        err_d        = err_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        if (reload) begin
            state_d   = LOAD_W;
            w_cnt_d   = '0;
            pix_cnt_d = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
        end else begin
            if (accept && (state_q == LOAD_W)) begin
                w_valid_d = 1'b1;
                w_addr_d  = w_cnt_q;
                w_data_d  = s_axis_tdata;
`ifdef LOADER_TLAST_CHECK_EN
                err_d = err_q | (s_axis_tlast != w_last);
`endif
                if (w_last) begin
                    state_d = STREAM;
                    w_cnt_d = '0;
                end else begin
                    w_cnt_d = w_cnt_q + 1'b1;
                end
            end
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                if (pix_cnt_q == PCW'(FRAME_PIXELS - 1)) begin
                    pix_cnt_d    = '0;
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 16'd1;
                end else begin
                    pix_cnt_d = pix_cnt_q + 1'b1;
                end
            end
            count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LOAD_W;
            w_cnt_q      <= '0;
            pix_cnt_q    <= '0;
            w_valid_q    <= 1'b0;
            w_addr_q     <= '0;
            w_data_q     <= '0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            err_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            w_cnt_q      <= w_cnt_d;
            pix_cnt_q    <= pix_cnt_d;
            w_valid_q    <= w_valid_d;
            w_addr_q     <= w_addr_d;
            w_data_q     <= w_data_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            err_q        <= err_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= s_axis_tdata[PIX_W-1:0];
    end

`ifndef LOADER_TLAST_CHECK_EN
    logic unused_tlast;
    assign unused_tlast = s_axis_tlast;
`endif

    assign w_valid        = w_valid_q;
    assign w_addr         = w_addr_q;
    assign w_data         = w_data_q;
    assign weights_loaded = (state_q == STREAM);
    assign pix_valid      = !fifo_empty;
    assign pix_data       = mem_q[rd_ptr_q];
    assign frame_done     = frame_done_q;
    assign frame_cnt      = frame_cnt_q;
    assign err_tlast      = err_q;

endmodule

// File: tb/tb_axis_stream_loader.sv
// tb/tb_axis_stream_loader.sv - directed scoreboard bench for axis_stream_loader.
module tb_axis_stream_loader;

    localparam int WC = 8;
    localparam int FP = 16;
    localparam int FD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] tdata = '0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic        tlast = 1'b0;
    logic        reload = 1'b0;
    logic        w_valid;
    logic [2:0]  w_addr;
    logic [31:0] w_data;
    logic        weights_loaded;
    logic        pix_valid;
    logic [23:0] pix_data;
    logic        pix_rd_en = 1'b0;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        err_tlast;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [23:0] pq [$];
    logic        m_stream = 1'b0;
    int          m_wcnt = 0;
    int          m_pcnt = 0;
    logic [15:0] m_fcnt = '0;
    logic        m_err = 1'b0;
    int          n_acc = 0;

    axis_stream_loader #(
        .DATA_W(32), .PIX_W(24), .WEIGHT_COUNT(WC), .FRAME_PIXELS(FP), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready), .s_axis_tlast(tlast),
        .reload(reload),
        .w_valid(w_valid), .w_addr(w_addr), .w_data(w_data),
        .weights_loaded(weights_loaded),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_rd_en(pix_rd_en),
        .frame_done(frame_done), .frame_cnt(frame_cnt), .err_tlast(err_tlast)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check combinational outputs before the edge, registered ones after it.
    task automatic tick();
        logic        exp_rdy, acc, popped, e_wv, e_fd;
        logic [31:0] e_wa, e_wd, d;
        #1;
        exp_rdy = !rst && !reload && (!m_stream || pq.size() < FD);
        chk("tready", {31'd0, tready}, {31'd0, exp_rdy});
        chk("pix_valid", {31'd0, pix_valid}, {31'd0, pq.size() != 0});
        acc    = tvalid && exp_rdy;
        popped = pix_rd_en && pq.size() != 0 && !rst && !reload;
        d      = tdata;
        if (popped) chk("pix_data", {8'd0, pix_data}, {8'd0, pq[0]});
        e_wv = 1'b0; e_wa = '0; e_wd = '0; e_fd = 1'b0;
        @(posedge clk);
        #1;
        if (rst) begin
            pq.delete(); m_stream = 1'b0; m_wcnt = 0; m_pcnt = 0; m_fcnt = '0; m_err = 1'b0;
        end else if (reload) begin
            pq.delete(); m_stream = 1'b0; m_wcnt = 0; m_pcnt = 0;
        end else begin
            if (popped) begin
                void'(pq.pop_front());
                if (m_pcnt == FP - 1) begin
                    m_pcnt = 0; m_fcnt++; e_fd = 1'b1;
                end else m_pcnt++;
            end
            if (acc) begin
                n_acc++;
                if (!m_stream) begin
                    e_wv = 1'b1; e_wa = m_wcnt; e_wd = d;
`ifdef LOADER_TLAST_CHECK_EN
                    if (tlast != (m_wcnt == WC - 1)) m_err = 1'b1;
`endif
                    if (m_wcnt == WC - 1) begin
                        m_stream = 1'b1; m_wcnt = 0;
                    end else m_wcnt++;
                end else pq.push_back(d[23:0]);
            end
        end
        chk("w_valid", {31'd0, w_valid}, {31'd0, e_wv});
        if (e_wv) begin
            chk("w_addr", {29'd0, w_addr}, e_wa);
            chk("w_data", w_data, e_wd);
        end
        chk("frame_done", {31'd0, frame_done}, {31'd0, e_fd});
        chk("weights_loaded", {31'd0, weights_loaded}, {31'd0, m_stream});
        chk("frame_cnt", {16'd0, frame_cnt}, {16'd0, m_fcnt});
        chk("err_tlast", {31'd0, err_tlast}, {31'd0, m_err});
    endtask

    task automatic load_weights(input int tlast_beat);
        for (int i = 0; i < WC; i++) begin
            tvalid = 1'b1; tdata = 32'hA0 + i; tlast = (i == tlast_beat);
            tick();
        end
        tvalid = 1'b0; tlast = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        tvalid = 1'b0; pix_rd_en = 1'b1;
        while (pq.size() != 0 && budget < 20) begin
            tick(); budget++;
        end
        chk("drain_timeout", {31'd0, pq.size() != 0}, 32'd0);
        pix_rd_en = 1'b0;
    endtask

    initial begin
        int budget, sent;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_w_valid", {31'd0, w_valid}, 32'd0);
        chk("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
        chk("rst_weights_loaded", {31'd0, weights_loaded}, 32'd0);
        chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        chk("rst_err", {31'd0, err_tlast}, 32'd0);
        chk("rst_tready", {31'd0, tready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("tready_after_rst", {31'd0, tready}, 32'd1);

        load_weights(WC - 1);
        tick();
        chk("loaded", {31'd0, weights_loaded}, 32'd1);

        // Two full frames with continuous popping
        sent = 0; budget = 0;
        pix_rd_en = 1'b1;
        while ((sent < 32 || pq.size() != 0) && budget < 200) begin
            tvalid = (sent < 32);
            tdata  = 32'h5500_0000 + sent;
            n_acc  = 0;
            tick();
            sent += n_acc;
            budget++;
        end
        tvalid = 1'b0; pix_rd_en = 1'b0;
        chk("frame_timeout", budget < 200 ? 32'd0 : 32'd1, 32'd0);
        chk("frame_cnt_2", {16'd0, frame_cnt}, 32'd2);

        // Backpressure: six presented beats, four fit
        sent = 0;
        for (int k = 0; k < 6; k++) begin
            tvalid = 1'b1; tdata = 32'h100 + sent; n_acc = 0;
            tick();
            sent += n_acc;
        end
        chk("bp_accepted", sent, 32'd4);
        pix_rd_en = 1'b1; tick(); pix_rd_en = 1'b0;
        chk("bp_tready_unblocked", {31'd0, tready}, 32'd1);
        n_acc = 0; tick();
        chk("bp_fifth_accepted", n_acc, 32'd1);
        tvalid = 1'b0;
        drain();

        // Pixel width truncation and ordering
        tvalid = 1'b1; tdata = 32'h1234_5678; tick();
        tdata = 32'hFFAB_CDEF; tick();
        tvalid = 1'b0;
        chk("pix_head_trunc", {8'd0, pix_data}, 32'h0034_5678);
        drain();

        // Reload with three pixels buffered and a beat presented
        for (int k = 0; k < 3; k++) begin
            tvalid = 1'b1; tdata = 32'h300 + k; tick();
        end
        reload = 1'b1; tdata = 32'h399; tick();
        reload = 1'b0; tvalid = 1'b0;
        chk("reload_pix_valid", {31'd0, pix_valid}, 32'd0);
        chk("reload_not_loaded", {31'd0, weights_loaded}, 32'd0);
        load_weights(5);
        tick();
        chk("reload_loaded", {31'd0, weights_loaded}, 32'd1);
        chk("reload_frame_cnt", {16'd0, frame_cnt}, 32'd2);
`ifdef LOADER_TLAST_CHECK_EN
        chk("err_tlast_set", {31'd0, err_tlast}, 32'd1);
`else
        chk("err_tlast_off", {31'd0, err_tlast}, 32'd0);
`endif
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/axis_stream_loader.md
Name: axis_stream_loader

Overview:
- Single AXI-stream ingress sequencer placed between the DMA and the model core.
- Phase 1 (LOAD_W): consumes exactly WEIGHT_COUNT words and emits them as addressed weight writes.
- Phase 2 (STREAM): buffers pixel words in an internal FIFO and serves them to the core through a show-ahead read port, counting frames.
- Generalises the split weight/data DMA feed into one parametrised stream with in-place reload.

Parameters:
- DATA_W, 32, AXI-stream word width.
- PIX_W, 24, pixel width; must be <= DATA_W; taken from tdata[PIX_W-1:0].
- WEIGHT_COUNT, 99678, words in the weight phase; must be >= 1.
- FRAME_PIXELS, 65536, pixels per frame; must be >= 1.
- FIFO_DEPTH, 16, pixel FIFO entries; power of 2, >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- s_axis_tdata  in  DATA_W  stream data.
- s_axis_tvalid  in  1  stream valid.
- s_axis_tready  out  1  stream ready.
- s_axis_tlast  in  1  stream last; marks the final weight word.
- reload  in  1  single-cycle pulse: abandon the current state and reload weights.
- w_valid  out  1  weight write strobe.
- w_addr  out  $clog2(WEIGHT_COUNT)  weight index.
- w_data  out  DATA_W  weight word.
- weights_loaded  out  1  high while in STREAM.
- pix_valid  out  1  FIFO not empty.
- pix_data  out  PIX_W  FIFO head.
- pix_rd_en  in  1  pop request from the core.
- frame_done  out  1  one-cycle pulse on the last pixel popped of each frame.
- frame_cnt  out  16  completed frames; wraps at 2^16.
- err_tlast  out  1  sticky tlast protocol error.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State = LOAD_W; weight counter = 0; pixel counter = 0; FIFO emptied.
  - All outputs 0, except s_axis_tready, which follows the LOAD_W rule on the next cycle.
- A beat is accepted when s_axis_tvalid & s_axis_tready at the clk edge.
- s_axis_tready is combinational:
  - 0 whenever reload=1 or rst=1.
  - LOAD_W: otherwise 1; the weight sink never stalls.
  - STREAM: otherwise !fifo_full. No same-cycle pop credit.
- LOAD_W:
  - Each accepted beat registers w_valid=1, w_addr=weight counter, w_data=tdata on the next cycle (latency 1). w_valid=0 otherwise.
  - The weight counter increments per beat.
  - The beat with counter == WEIGHT_COUNT-1 moves the state to STREAM. weights_loaded=1 from the next cycle.
  - The first beat after that is a pixel.
- STREAM:
  - Each accepted beat pushes tdata[PIX_W-1:0]; upper bits are discarded.
  - Show-ahead read: pix_valid=!empty; pix_data=head, valid in the same cycle.
  - Pop occurs when pix_rd_en & pix_valid. pix_rd_en while empty is ignored and is not an error.
  - Push and pop in the same cycle when full: push blocked (tready=0), pop proceeds.
  - Push and pop in the same cycle when not full: occupancy unchanged.
  - A pushed word is visible on pix_data the cycle after acceptance, at the earliest.
- Frame counting:
  - The pixel counter counts pops.
  - On the pop where counter == FRAME_PIXELS-1: frame_done=1 on the next cycle, counter returns to 0, frame_cnt increments.
- reload=1 (any state):
  - The current-cycle beat is not accepted.
  - Next cycle: state LOAD_W, FIFO flushed, weight and pixel counters 0, weights_loaded=0, w_valid=0, pix_valid=0.
  - frame_cnt and err_tlast are preserved; only rst clears them.
- rst has priority over reload.

Optional Feature:
- Macro: LOADER_TLAST_CHECK_EN.
- Defined:
  - In LOAD_W, err_tlast is set if tlast=1 on an accepted beat with counter != WEIGHT_COUNT-1.
  - It is also set if tlast=0 on the beat with counter == WEIGHT_COUNT-1.
  - Sticky until rst. The load still proceeds by count.
  - tlast is ignored in STREAM.
- Undefined: err_tlast tied to 0; tlast ignored entirely; the port is kept for a stable interface.

Test Plan (WEIGHT_COUNT=8, FRAME_PIXELS=16, FIFO_DEPTH=4 unless stated):
- Weight load: 8 beats 0xA0..0xA7, tvalid held high, tlast on beat 7 -> w_valid for 8 consecutive cycles, w_addr 0..7, w_data 0xA0..0xA7, each 1 cycle after acceptance. weights_loaded=1 the cycle after beat 7; err_tlast=0.
- Backpressure: after load, push 6 pixels with pix_rd_en=0 -> 4 accepted, tready=0 from the 5th. One pop -> tready=1 the same cycle it is combinationally unblocked, and the 5th pixel is accepted the next edge.
- Pixel width/order: push 0x12345678, 0xFFABCDEF -> pix_data 0x345678 then 0xABCDEF, in order, with no duplicates.
- Frame: stream 32 pixels with pix_rd_en=1 -> frame_done pulses exactly twice, after pops 16 and 32; frame_cnt reads 2.
- Reload: 3 pixels buffered, reload pulsed with tvalid=1 -> that beat is not accepted; pix_valid=0 next cycle. The following 8 beats appear as w_addr 0..7; frame_cnt unchanged.
- With LOADER_TLAST_CHECK_EN: tlast on beat 5 of 8 -> err_tlast=1 and stays 1; the load still completes at beat 7. Without the macro, the same stimulus leaves err_tlast=0.
